// File: rtl/capi_parity_checker.sv
// Receive-side CAPI parity checker: two-stage pipeline that recomputes per-double-word
// parity, forwards the beat unchanged, and tracks first-error capture plus a saturating count.
module capi_parity_checker #(
  parameter int DOUBLE_WORDS = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                      i_clock,
  input  logic                      i_rstn,
  input  logic                      i_odd,
  input  logic                      i_enable,
  input  logic                      i_in_valid,
  input  logic [64*DOUBLE_WORDS-1:0] i_in_data,
  input  logic [DOUBLE_WORDS-1:0]   i_in_par,
  input  logic                      i_err_clear,
  output logic                      o_out_valid,
  output logic [64*DOUBLE_WORDS-1:0] o_out_data,
  output logic                      o_err_valid,
  output logic [DOUBLE_WORDS-1:0]   o_err_mask,
  output logic                      o_err_sticky,
  output logic [DOUBLE_WORDS-1:0]   o_first_err_mask,
  output logic [COUNT_WIDTH-1:0]    o_err_count
);

  localparam int DATA_W = 64 * DOUBLE_WORDS;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic {CLEAN = 1'b0, ERRORED = 1'b1} state_t;

  // Stage 1 registers
  logic                    r_s1_valid;
  logic [DATA_W-1:0]       r_s1_data;
  logic [DOUBLE_WORDS-1:0] r_s1_par;
  logic                    r_s1_odd;
  logic                    r_s1_enable;

  // Stage 2 / output registers
  logic                    r_out_valid;
  logic [DATA_W-1:0]       r_out_data;
  logic [DOUBLE_WORDS-1:0] r_err_mask;

  // Sticky error tracking
  state_t                  r_state;
  logic [DOUBLE_WORDS-1:0] r_first_mask;
  logic [COUNT_WIDTH-1:0]  r_count;

  logic [DOUBLE_WORDS-1:0] w_mismatch;
  logic [DOUBLE_WORDS-1:0] w_err_mask;
  logic                    w_stage_err;
  state_t                  w_state_next;
  logic [DOUBLE_WORDS-1:0] w_first_mask_next;
  logic [COUNT_WIDTH-1:0]  w_count_next;

  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_par    <= '0;
      r_s1_odd    <= 1'b0;
      r_s1_enable <= 1'b0;
    end else begin
      r_s1_valid  <= i_in_valid;
      r_s1_odd    <= i_odd;
      r_s1_enable <= i_enable;
      if (i_in_valid) begin
        r_s1_data <= i_in_data;
        r_s1_par  <= i_in_par;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DOUBLE_WORDS; gi++) begin : g_dw_parity
      assign w_mismatch[gi] = (^{r_s1_data[64*gi +: 64], r_s1_odd}) != r_s1_par[gi];
    end
  endgenerate

  assign w_err_mask  = (r_s1_valid && r_s1_enable) ? w_mismatch : '0;
  assign w_stage_err = |w_err_mask;

  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err_mask  <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_out_data  <= r_s1_data;
      r_err_mask  <= w_err_mask;
    end
  end

  // A new error always wins over a coincident clear and restarts the capture.
  always_comb begin
    w_state_next      = r_state;
    w_first_mask_next = r_first_mask;
    w_count_next      = r_count;
    if (w_stage_err) begin
      if (r_state == CLEAN || i_err_clear) begin
        w_state_next      = ERRORED;
        w_first_mask_next = w_err_mask;
        w_count_next      = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (r_count != COUNT_MAX) begin
        w_count_next = r_count + 1'b1;
      end
    end else if (i_err_clear) begin
      w_state_next      = CLEAN;
      w_first_mask_next = '0;
      w_count_next      = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= CLEAN;
      r_first_mask <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_first_mask <= w_first_mask_next;
      r_count      <= w_count_next;
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_out_data       = r_out_data;
  assign o_err_mask       = r_err_mask;
  assign o_err_valid      = |r_err_mask;
  assign o_err_sticky     = (r_state == ERRORED);
  assign o_first_err_mask = r_first_mask;
  assign o_err_count      = r_count;

endmodule

// File: tb/tb_capi_parity_checker.sv
// Bench for capi_parity_checker (2 double words, 2-bit counter): directed cases then
// randomized beats checked against a history-based parity/sticky model.
module tb_capi_parity_checker;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           odd = 1'b0;
  logic           en = 1'b0;
  logic           v = 1'b0;
  logic           clr = 1'b0;
  logic [127:0]   d = '0;
  logic [1:0]     p = '0;

  logic           out_valid;
  logic [127:0]   out_data;
  logic           err_valid;
  logic [1:0]     err_mask;
  logic           err_sticky;
  logic [1:0]     first_err_mask;
  logic [CW-1:0]  err_count;

  capi_parity_checker #(.DOUBLE_WORDS(DW), .COUNT_WIDTH(CW)) dut (
    .i_clock(clk), .i_rstn(rstn), .i_odd(odd), .i_enable(en),
    .i_in_valid(v), .i_in_data(d), .i_in_par(p), .i_err_clear(clr),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_err_valid(err_valid),
    .o_err_mask(err_mask), .o_err_sticky(err_sticky),
    .o_first_err_mask(first_err_mask), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic         v;
    logic [127:0] d;
    logic [1:0]   p;
    logic         o;
    logic         en;
  } beat_t;

  // Model: what was offered at each edge; the output after an edge shows the
  // beat offered one edge earlier. Data/parity are held when a beat is not valid.
  beat_t     hist[$];
  logic      m_err;
  logic [1:0] m_first;
  int        m_count;

  function automatic logic [1:0] good_par(input logic [127:0] dd, input logic o);
    logic [1:0] r;
    for (int i = 0; i < DW; i++)
      r[i] = (($countones(dd[64*i +: 64]) + int'(o)) % 2) == 1;
    return r;
  endfunction

  function automatic logic [1:0] exp_mask(input beat_t b);
    if (!(b.v && b.en)) return 2'b00;
    return good_par(b.d, b.o) ^ b.p;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    m_err = 1'b0;
    m_first = 2'b00;
    m_count = 0;
  endtask

  task automatic step(input logic iv, input logic [127:0] id, input logic [1:0] ip,
                      input logic io, input logic ie, input logic ic);
    beat_t b, ob;
    logic [1:0] mk;
    v = iv; d = id; p = ip; odd = io; en = ie; clr = ic;
    @(posedge clk);
    #1;
    b.v = iv; b.d = id; b.p = ip; b.o = io; b.en = ie;
    if (!iv) begin
      b.d = hist[$].d;
      b.p = hist[$].p;
    end
    hist.push_back(b);
    ob = hist[hist.size()-2];
    if (hist.size() > 4) void'(hist.pop_front());
    mk = exp_mask(ob);
    if (mk != 2'b00) begin
      if (!m_err || ic) begin
        m_err = 1'b1; m_first = mk; m_count = 1;
      end else if (m_count < CMAX) begin
        m_count++;
      end
    end else if (ic) begin
      m_err = 1'b0; m_first = 2'b00; m_count = 0;
    end
    check("out_valid", out_valid, ob.v);
    check("out_data", out_data, ob.d);
    check("err_mask", err_mask, mk);
    check("err_valid", err_valid, |mk);
    check("err_sticky", err_sticky, m_err);
    check("first_err_mask", first_err_mask, m_first);
    check("err_count", err_count, m_count);
    if (ob.v)
      $display("beat data=%h mask=%b sticky=%0b first=%b count=%0d",
               out_data, err_mask, err_sticky, first_err_mask, err_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [127:0] rd;
    logic [1:0]   rp;
    logic         ro;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_count", err_count, '0);
    check("reset_sticky", err_sticky, 1'b0);
    rstn = 1'b1;

    // Clean beat, then single failing beat (dw0 bad)
    step(1'b1, '0, 2'b11, 1'b1, 1'b1, 1'b0);
    idle(2);
    step(1'b1, '0, 2'b10, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("first_after_one", first_err_mask, 2'b01);

    // Clear, then five failing beats: masks 01,10,11,01,01 -> counts saturate at 3
    step(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1);
    step(1'b1, '0, 2'b10, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 2'b01, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 2'b10, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 2'b10, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("sat_count", err_count, 2'd3);
    check("sat_first", first_err_mask, 2'b01);

    // Clear alone
    step(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1);
    check("clear_sticky", err_sticky, 1'b0);

    // Error then clear-coincident error (mask 10): error wins
    step(1'b1, '0, 2'b10, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 2'b01, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b1);
    check("coinc_first", first_err_mask, 2'b10);
    check("coinc_count", err_count, 2'd1);

    // Async reset with a failing beat in flight
    step(1'b1, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    v = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_sticky", err_sticky, 1'b0);
    check("arst_count", err_count, '0);
    check("arst_mask", err_mask, 2'b00);
    #3 rstn = 1'b1;
    model_reset();
    idle(3);

    // Failing beat with enable low: forwarded, not flagged
    rd = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, rd, ~good_par(rd, 1'b0), 1'b0, 1'b0, 1'b0);
    idle(1);
    check("noen_data", out_data, rd);
    check("noen_errv", err_valid, 1'b0);
    idle(1);

    // Randomized stream
    ro = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(15) == 0) ro = ~ro;
      rp = good_par(rd, ro);
      if ($urandom_range(3) == 0) rp = rp ^ 2'($urandom_range(3));
      step($urandom_range(3) != 0, rd, rp, ro, $urandom_range(7) != 0,
           $urandom_range(9) == 0);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/capi_parity_checker.md
Name: capi_parity_checker

Overview:
- Receive-side parity checker for CAPI buses carrying per-double-word parity (PSL→AFU command response, buffer write data).
- Recomputes parity per 64-bit double word, compares it with the received parity bits, and forwards the data unchanged.
- Produces a per-beat error mask, a sticky error flag, a capture of the first failing beat, and a saturating error counter for the AFU error/MMIO logic.

Parameters:
- DOUBLE_WORDS, 1, number of 64-bit double words per beat; one parity bit per double word.
- COUNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clock  input  1  single clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- odd  input  1  parity sense. Expected parity per double word is ^{dw, odd}. Quasi-static; sampled with each beat.
- enable  input  1  0: beats pass through, no error is flagged or counted.
- in_valid  input  1  beat qualifier.
- in_data  input  64*DOUBLE_WORDS  [0:N-1] big-endian; dw i = in_data[64*i +: 64].
- in_par  input  DOUBLE_WORDS  received parity; in_par[i] covers dw i.
- err_clear  input  1  single-cycle pulse; clears sticky state.
- out_valid  output  1  delayed in_valid.
- out_data  output  64*DOUBLE_WORDS  delayed in_data, unmodified.
- err_valid  output  1  pulses with out_valid when any double word failed.
- err_mask  output  DOUBLE_WORDS  per-dw failure flags for the current out beat; bit i = dw i.
- err_sticky  output  1  set on any error; held until err_clear or reset.
- first_err_mask  output  DOUBLE_WORDS  err_mask of the first failing beat since the last clear.
- err_count  output  COUNT_WIDTH  number of failing beats, saturating at all-ones.

Behaviour:
- Reset (rstn=0, async): every output and internal register goes to 0. A beat in flight is discarded and never appears at the output.
- Stage 1 (cycle T+1): register in_valid, in_data, in_par, odd, enable. in_data and in_par load only when in_valid=1; valid always loads.
- Stage 2 (cycle T+2): mismatch[i] = (^{dw_i, odd_r}) != par_r[i].
  - err_mask = valid_r & enable_r ? mismatch : 0.
  - out_valid and out_data are registered.
  - Latency from in_valid to out_valid is exactly 2 cycles. Throughput is one beat per cycle, with no bubbles and no backpressure.
- err_valid = |err_mask, aligned with out_valid. err_mask is 0 whenever out_valid=0.
- The sticky state machine (CLEAN, ERRORED) updates in the same cycle err_valid is asserted:
  - CLEAN → ERRORED on err_valid: err_sticky=1, first_err_mask=err_mask, err_count=1.
  - ERRORED, further err_valid: first_err_mask is held; err_count+1, saturating at 2^COUNT_WIDTH-1 with no wrap.
  - err_clear (stage-2 error not asserted that cycle) → CLEAN: sticky, first_err_mask and count go to 0 next cycle.
  - err_clear coincident with a stage-2 error: the error wins. State is ERRORED, first_err_mask = the new mask, count = 1.
- err_clear affects only the sticky state; the pipeline and data are unaffected.
- enable deasserted mid-stream applies only to beats sampled while it is low.
- odd changes take effect per beat, with no glitch on beats already in flight.
- DOUBLE_WORDS=1 is legal; the masks are then 1 bit wide.

Test Plan:
- DOUBLE_WORDS=2, odd=1: in_data=0, in_par=2'b11 → out_valid at T+2, err_valid=0, out_data=0, err_count=0.
- Same beat with in_par=2'b10 → err_mask=2'b01, err_valid=1, err_sticky=1, first_err_mask=2'b01, err_count=1.
- Three consecutive failing beats with masks 01, 10, 11 → first_err_mask stays 01; err_count=3; per-beat err_mask matches each beat in order.
- COUNT_WIDTH=2, five failing beats → err_count reads 1, 2, 3, 3, 3. Then err_clear alone → all sticky outputs 0 one cycle later.
- err_clear in the same cycle as a failing beat (mask 10) → err_sticky=1, first_err_mask=10, err_count=1.
- Failing beat launched, then rstn pulsed low at T+1 → outputs 0 immediately; no out_valid and no count after release. A failing beat with enable=0 → err_valid=0, and data is still forwarded.
